// File: rtl/seven_seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Package   : seven_seg_pkg
// Purpose   : Segment code constants, segment bit positions and width helper
//             shared by the seven-segment display blocks.
// Revision  : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Segment bit positions inside {dp,g,f,e,d,c,b,a}
    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_B  = 1;
    localparam int SEG_BIT_C  = 2;
    localparam int SEG_BIT_D  = 3;
    localparam int SEG_BIT_E  = 4;
    localparam int SEG_BIT_F  = 5;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;

    // Active-high gfedcba patterns
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bits needed to count n states; never less than one bit
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : seven_seg_scan_driver_if
// Purpose   : Digit data / load strobe from the datapath and scanned display
//             pin outputs of the seven-segment scan driver.
// Revision  : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 5
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   seg_sel;
    logic [7:0]              seg_data;
    logic                    frame_done;

    // Datapath side: supplies digit data, observes the display outputs
    modport master (
        output digits_in, dp_in, blank_in, load,
        input  seg_sel, seg_data, frame_done
    );

    // Driver side
    modport slave (
        input  digits_in, dp_in, blank_in, load,
        output seg_sel, seg_data, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_driver_dec.sv
`default_nettype none
// ============================================================================
// Module    : seg_hex_decoder
// Purpose   : 4-bit digit code to active-high gfedcba segment pattern.
//             Codes 10..15 show A,b,C,d,E,F when i_hex_en, else blank.
// Revision  : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_hex_en,
    output logic [6:0] o_seg
);

    // Pure lookup; hex letters are gated off when hex display is disabled
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = i_hex_en ? SEG_A : SEG_BLANK;
            4'hB: o_seg = i_hex_en ? SEG_B : SEG_BLANK;
            4'hC: o_seg = i_hex_en ? SEG_C : SEG_BLANK;
            4'hD: o_seg = i_hex_en ? SEG_D : SEG_BLANK;
            4'hE: o_seg = i_hex_en ? SEG_E : SEG_BLANK;
            4'hF: o_seg = i_hex_en ? SEG_F : SEG_BLANK;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module    : seven_seg_scan_driver
// Purpose   : Time-multiplexed common-bus seven-segment driver. Shadows a
//             packed digit word, scans digits with a one-hot select, applies
//             anti-ghost gap, blanking and optional leading-zero suppression.
// Revision  : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int CLK_DIV      = 50000,
    parameter int GHOST_CYCLES = 2,
    parameter int HEX_EN       = 1,
    parameter int LZ_BLANK     = 0
)(
    input  logic                     clk,
    input  logic                     rst_n,
    seven_seg_scan_driver_if.slave   bus
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int DIV_W = idx_width(CLK_DIV);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic             c_hex_en   = (HEX_EN != 0);
    localparam logic             c_lz_en    = (LZ_BLANK != 0);

    // Shadow copies of the datapath inputs
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;

    // Scan position
    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;

    // Registered pin drivers
    logic [NUM_DIGITS-1:0]   r_seg_sel;
    logic [7:0]              r_seg_data;
    logic                    r_frame_done;

    logic                    w_div_wrap;
    logic                    w_idx_last;
    logic                    w_ghost;
    logic                    w_blank_now;
    logic [3:0]              w_code;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [7:0]              w_data;
    logic [NUM_DIGITS-1:0]   w_zero_above;
    logic [NUM_DIGITS-1:0]   w_lz_blank;

    // Leading-zero detection: digit i is a leading zero when it and every
    // more-significant code are zero; digit 0 is always shown.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == NUM_DIGITS - 1) begin : g_top
            assign w_zero_above[i] = (r_digits[4*i +: 4] == 4'h0);
        end else begin : g_mid
            assign w_zero_above[i] = (r_digits[4*i +: 4] == 4'h0) && w_zero_above[i+1];
        end
        if (i == 0) begin : g_lsd
            assign w_lz_blank[i] = 1'b0;
        end else begin : g_msd
            assign w_lz_blank[i] = c_lz_en && w_zero_above[i];
        end
    end

    assign w_div_wrap  = (r_div == c_div_last);
    assign w_idx_last  = (r_idx == c_idx_last);
    assign w_ghost     = (32'(r_div) < GHOST_CYCLES);
    assign w_code      = r_digits[{r_idx, 2'b00} +: 4];
    assign w_blank_now = r_blank[r_idx] | w_lz_blank[r_idx];
    assign w_sel       = NUM_DIGITS'(1) << r_idx;
    assign w_data      = (w_ghost || w_blank_now) ? 8'h00 : {r_dp[r_idx], w_seg};

    seg_hex_decoder u_dec (
        .i_code   (w_code),
        .i_hex_en (c_hex_en),
        .o_seg    (w_seg)
    );

    // Capture new display content on the load strobe; dark until first load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_dp     <= '0;
            r_blank  <= '1;
        end else if (bus.load) begin
            r_digits <= bus.digits_in;
            r_dp     <= bus.dp_in;
            r_blank  <= bus.blank_in;
        end
    end

    // Slot divider and digit index; index wraps explicitly at the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Register the pin outputs one cycle behind the scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_sel    <= NUM_DIGITS'(1);
            r_seg_data   <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_seg_sel    <= w_sel;
            r_seg_data   <= w_data;
            r_frame_done <= w_div_wrap && w_idx_last;
        end
    end

    assign bus.seg_sel    = r_seg_sel;
    assign bus.seg_data   = r_seg_data;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
